// File: rtl/enemy_bullet_if.sv
// Enemy bullet bus: frame strobe, fire request, enemy/player positions in,
// bullet position, existence, hit/block pulses and ready flag out.
//   master : game-control side (drives tick/fire/positions, reads bullet state)
//   slave  : enemy_bullet block
interface enemy_bullet_if;
  logic               tick;
  logic               fire;
  logic signed [10:0] xEnemy;
  logic signed [9:0]  yEnemy;
  logic signed [10:0] xPlayer;
  logic signed [9:0]  yPlayer;
  logic               isQ;
  logic               defend;
  logic signed [10:0] x;
  logic signed [9:0]  y;
  logic               isE;
  logic               isHit;
  logic               isBlocked;
  logic               ready;

  modport master (
    output tick, fire, xEnemy, yEnemy, xPlayer, yPlayer, isQ, defend,
    input  x, y, isE, isHit, isBlocked, ready
  );

  modport slave (
    input  tick, fire, xEnemy, yEnemy, xPlayer, yPlayer, isQ, defend,
    output x, y, isE, isHit, isBlocked, ready
  );
endinterface

// File: rtl/enemy_bullet.sv
// Enemy projectile travelling right-to-left toward the player.
// Spawns on a fire request (sampled on the frame tick while READY), moves
// BULLET_STEP_X px left per tick, reports a hit or shield block against the
// player, then waits COOLDOWN ticks before the next shot can be fired.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : enemy_bullet_if.slave (tick, fire, positions in; x, y, isE,
//          isHit, isBlocked, ready out)
module enemy_bullet #(
  parameter int MAP_X          = 640,
  parameter int BULLET_STEP_X  = 8,
  parameter int BULLET_X       = 4,
  parameter int BULLET_Y       = 4,
  parameter int PLAYER_X       = 16,
  parameter int PLAYER_Y       = 32,
  parameter int SQUAT_PLAYER_Y = 16,
  parameter int COOLDOWN       = 30
) (
  input  logic          clk,
  input  logic          rst,
  enemy_bullet_if.slave bus
);

  localparam int CNT_W = $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Collision math runs one bit wider than the coordinates so nothing wraps.
  localparam logic signed [11:0] STEP12 = 12'(BULLET_STEP_X);
  localparam logic signed [11:0] BX12   = 12'(BULLET_X);
  localparam logic signed [11:0] BY12   = 12'(BULLET_Y);
  localparam logic signed [11:0] PX12   = 12'(PLAYER_X);
  localparam logic signed [11:0] PY12   = 12'(PLAYER_Y);
  localparam logic signed [11:0] SQH12  = 12'(SQUAT_PLAYER_Y);
  localparam logic signed [10:0] PX11   = 11'(PLAYER_X);
  localparam logic signed [10:0] BX11   = 11'(BULLET_X);

  typedef enum logic [1:0] {READY, FLY, RELOAD} state_t;

  function automatic logic signed [11:0] sx11(input logic signed [10:0] v);
    return {v[10], v};
  endfunction

  function automatic logic signed [11:0] sy10(input logic signed [9:0] v);
    return {{2{v[9]}}, v};
  endfunction

  state_t             state, state_d;
  logic signed [10:0] x_q, x_d;
  logic signed [9:0]  y_q, y_d;
  logic               ise_q, ise_d;
  logic               hit_q, hit_d;
  logic               blk_q, blk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [11:0] xn;
  logic signed [11:0] half_h;
  logic               h_ovl;
  logic               v_ovl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= READY;
      x_q   <= '0;
      y_q   <= '0;
      ise_q <= 1'b0;
      hit_q <= 1'b0;
      blk_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      x_q   <= x_d;
      y_q   <= y_d;
      ise_q <= ise_d;
      hit_q <= hit_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    x_d     = x_q;
    y_d     = y_q;
    ise_d   = ise_q;
    hit_d   = 1'b0;
    blk_d   = 1'b0;
    cnt_d   = cnt_q;

    xn     = sx11(x_q) - STEP12;
    half_h = bus.isQ ? SQH12 : PY12;
    h_ovl  = (xn - BX12) < (sx11(bus.xPlayer) + PX12);
    // A squatting player lowers only the top edge; the bottom edge is fixed.
    v_ovl  = ((sy10(y_q) + BY12) > (sy10(bus.yPlayer) - half_h)) &&
             ((sy10(y_q) - BY12) < (sy10(bus.yPlayer) + PY12));

    if (bus.tick) begin
      unique case (state)
        READY: begin
          if (bus.fire) begin
            x_d     = bus.xEnemy - PX11 - BX11;
            y_d     = bus.yEnemy;
            ise_d   = 1'b1;
            state_d = FLY;
          end
        end
        FLY: begin
          // Hit is tested first so it wins over leaving the left edge.
          if (h_ovl && v_ovl) begin
            hit_d   = ~bus.defend;
            blk_d   = bus.defend;
            ise_d   = 1'b0;
            x_d     = xn[10:0];
            cnt_d   = CNT_INIT;
            state_d = RELOAD;
          end else if (xn < BX12) begin
            ise_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = RELOAD;
          end else begin
            x_d = xn[10:0];
          end
        end
        RELOAD: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_d == CNT_ZERO) state_d = READY;
        end
        default: state_d = READY;
      endcase
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.isE       = ise_q;
  assign bus.isHit     = hit_q;
  assign bus.isBlocked = blk_q;
  assign bus.ready     = (state == READY);

endmodule

// File: tb/tb_enemy_bullet.sv
module tb_enemy_bullet;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  enemy_bullet_if bus();

  enemy_bullet dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick strobe; returns on the falling edge after the tick was applied.
  task automatic step_tick();
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic run_ticks(input int n, output int pulses, output int drops);
    pulses = 0;
    drops  = 0;
    for (int i = 0; i < n; i++) begin
      step_tick();
      if (bus.isHit || bus.isBlocked) pulses++;
      if (!bus.isE) drops++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic shoot(input logic signed [10:0] xe, input logic signed [9:0] ye);
    bus.xEnemy = xe;
    bus.yEnemy = ye;
    bus.fire   = 1'b1;
    step_tick();
    bus.fire   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.x !== 11'sd0) begin errors++; $display("FAIL reset_x got %0d exp 0", bus.x); end
    checks++; if (bus.y !== 10'sd0) begin errors++; $display("FAIL reset_y got %0d exp 0", bus.y); end
    checks++; if (bus.isE !== 1'b0) begin errors++; $display("FAIL reset_isE got %b exp 0", bus.isE); end
    checks++; if (bus.isHit !== 1'b0 || bus.isBlocked !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got %b%b exp 00", bus.isHit, bus.isBlocked); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    rst = 1'b0;
  endtask

  task automatic test_spawn();
    apply_reset();
    bus.xPlayer = -11'sd500;
    bus.yPlayer = -10'sd400;
    bus.isQ = 1'b0;
    bus.defend = 1'b0;
    bus.xEnemy = 11'sd500;
    bus.yEnemy = 10'sd240;
    bus.fire = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.isE !== 1'b0) begin errors++; $display("FAIL spawn_without_tick isE got %b exp 0", bus.isE); end
    step_tick();
    bus.fire = 1'b0;
    checks++; if (bus.x !== 11'sd480) begin errors++; $display("FAIL spawn_x got %0d exp 480", bus.x); end
    checks++; if (bus.y !== 10'sd240) begin errors++; $display("FAIL spawn_y got %0d exp 240", bus.y); end
    checks++; if (bus.isE !== 1'b1 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL spawn_flags isE/ready got %b/%b exp 1/0", bus.isE, bus.ready); end
    bus.yEnemy = 10'sd100;
    step_tick();
    checks++; if (bus.x !== 11'sd472) begin errors++; $display("FAIL step_x got %0d exp 472", bus.x); end
    checks++; if (bus.y !== 10'sd240) begin errors++; $display("FAIL frozen_y got %0d exp 240", bus.y); end
  endtask

  task automatic test_reset_mid_fly();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.isE !== 1'b0 || bus.x !== 11'sd0) begin
      errors++; $display("FAIL midfly_reset isE/x got %b/%0d exp 0/0", bus.isE, bus.x); end
    checks++; if (bus.ready !== 1'b1 || bus.isHit !== 1'b0) begin
      errors++; $display("FAIL midfly_reset ready/isHit got %b/%b exp 1/0", bus.ready, bus.isHit); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hit_or_block(input logic dfd);
    int pulses, drops;
    apply_reset();
    bus.xPlayer = 11'sd100;
    bus.yPlayer = 10'sd240;
    bus.isQ = 1'b0;
    bus.defend = dfd;
    shoot(11'sd500, 10'sd240);
    run_ticks(45, pulses, drops);
    checks++; if (pulses !== 0 || drops !== 0) begin
      errors++; $display("FAIL hb%0d_approach pulses/drops got %0d/%0d exp 0/0", dfd, pulses, drops); end
    checks++; if (bus.x !== 11'sd120) begin errors++; $display("FAIL hb%0d_prehit_x got %0d exp 120", dfd, bus.x); end
    step_tick();
    checks++; if (bus.isHit !== ~dfd || bus.isBlocked !== dfd) begin
      errors++; $display("FAIL hb%0d_pulse isHit/isBlocked got %b/%b exp %b/%b", dfd, bus.isHit, bus.isBlocked, ~dfd, dfd); end
    checks++; if (bus.isE !== 1'b0 || bus.x !== 11'sd112) begin
      errors++; $display("FAIL hb%0d_after isE/x got %b/%0d exp 0/112", dfd, bus.isE, bus.x); end
    @(negedge clk);
    checks++; if (bus.isHit !== 1'b0 || bus.isBlocked !== 1'b0) begin
      errors++; $display("FAIL hb%0d_one_cycle got %b%b exp 00", dfd, bus.isHit, bus.isBlocked); end
    run_ticks(29, pulses, drops);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL hb%0d_ready_29 got %b exp 0", dfd, bus.ready); end
    step_tick();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL hb%0d_ready_30 got %b exp 1", dfd, bus.ready); end
  endtask

  task automatic test_squat();
    int pulses, drops;
    apply_reset();
    bus.xPlayer = 11'sd100;
    bus.yPlayer = 10'sd200;
    bus.isQ = 1'b1;
    bus.defend = 1'b0;
    shoot(11'sd500, 10'sd170);
    run_ticks(59, pulses, drops);
    checks++; if (pulses !== 0 || drops !== 0 || bus.x !== 11'sd8) begin
      errors++; $display("FAIL squat_pass pulses/drops/x got %0d/%0d/%0d exp 0/0/8", pulses, drops, bus.x); end
    step_tick();
    checks++; if (bus.isE !== 1'b0 || bus.isHit !== 1'b0 || bus.isBlocked !== 1'b0 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL squat_exit isE/isHit/isBlocked/ready got %b/%b/%b/%b exp 0/0/0/0",
                         bus.isE, bus.isHit, bus.isBlocked, bus.ready); end
    apply_reset();
    bus.isQ = 1'b0;
    shoot(11'sd500, 10'sd170);
    run_ticks(45, pulses, drops);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL stand_early pulses got %0d exp 0", pulses); end
    step_tick();
    checks++; if (bus.isHit !== 1'b1 || bus.isE !== 1'b0) begin
      errors++; $display("FAIL stand_hit isHit/isE got %b/%b exp 1/0", bus.isHit, bus.isE); end
  endtask

  task automatic test_edge_priority();
    int pulses, drops;
    apply_reset();
    bus.xPlayer = -11'sd12;
    bus.yPlayer = 10'sd240;
    bus.isQ = 1'b0;
    bus.defend = 1'b0;
    shoot(11'sd500, 10'sd240);
    run_ticks(59, pulses, drops);
    checks++; if (pulses !== 0 || bus.x !== 11'sd8) begin
      errors++; $display("FAIL edge_pre pulses/x got %0d/%0d exp 0/8", pulses, bus.x); end
    step_tick();
    checks++; if (bus.isHit !== 1'b1 || bus.isE !== 1'b0 || bus.x !== 11'sd0) begin
      errors++; $display("FAIL edge_priority isHit/isE/x got %b/%b/%0d exp 1/0/0", bus.isHit, bus.isE, bus.x); end
  endtask

  task automatic test_back_to_back();
    int pulses, drops;
    apply_reset();
    bus.xPlayer = 11'sd460;
    bus.yPlayer = 10'sd240;
    bus.isQ = 1'b0;
    bus.defend = 1'b0;
    shoot(11'sd500, 10'sd240);
    bus.fire = 1'b1;
    step_tick();
    checks++; if (bus.isHit !== 1'b1) begin errors++; $display("FAIL b2b_first_hit got %b exp 1", bus.isHit); end
    run_ticks(29, pulses, drops);
    checks++; if (drops !== 29 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL b2b_reload drops/ready got %0d/%b exp 29/0", drops, bus.ready); end
    step_tick();
    checks++; if (bus.ready !== 1'b1 || bus.isE !== 1'b0) begin
      errors++; $display("FAIL b2b_ready ready/isE got %b/%b exp 1/0", bus.ready, bus.isE); end
    bus.xPlayer = -11'sd500;
    step_tick();
    checks++; if (bus.isE !== 1'b1 || bus.x !== 11'sd480 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL b2b_respawn isE/x/ready got %b/%0d/%b exp 1/480/0", bus.isE, bus.x, bus.ready); end
    step_tick();
    checks++; if (bus.x !== 11'sd472) begin errors++; $display("FAIL b2b_single_spawn x got %0d exp 472", bus.x); end
    bus.fire = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.fire = 1'b0;
    bus.xEnemy = '0;
    bus.yEnemy = '0;
    bus.xPlayer = '0;
    bus.yPlayer = '0;
    bus.isQ = 1'b0;
    bus.defend = 1'b0;
    test_reset();
    test_spawn();
    test_reset_mid_fly();
    test_hit_or_block(1'b0);
    test_hit_or_block(1'b1);
    test_squat();
    test_edge_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
